// File: rtl/pipelined_adder_if.sv
// ============================================================================
// Module      : pipelined_adder_if
// Description : Operand/result handshake bundle for pipelined_adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipelined_adder_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] lt;
    logic [WIDTH-1:0] rt;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             zero;

    // master drives operands and consumes results; slave is the adder
    modport master (
        output in_valid, lt, rt, cin, sub, out_ready,
        input  in_ready, out_valid, s, cout, ovf, zero
    );

    modport slave (
        input  in_valid, lt, rt, cin, sub, out_ready,
        output in_ready, out_valid, s, cout, ovf, zero
    );
endinterface

`default_nettype wire

// File: rtl/pipelined_adder.sv
// ============================================================================
// Module      : pipelined_adder
// Description : WIDTH-bit add/subtract, one CHUNK-bit slice per pipeline stage,
//               valid/ready handshake with full-pipeline backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipelined_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    pipelined_adder_if.slave bus
);
    localparam int STAGES = WIDTH / CHUNK;
    localparam int c_NPIPE = (STAGES > 1) ? STAGES - 1 : 1;
    localparam int c_LAST  = STAGES - 1;

    generate
        if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("pipelined_adder: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    logic             w_advance;
    logic [WIDTH-1:0] w_a_in  [STAGES];
    logic [WIDTH-1:0] w_b_in  [STAGES];
    logic [WIDTH-1:0] w_a_out [STAGES];
    logic             w_c_in  [STAGES];
    logic             w_v_in  [STAGES];
    logic [CHUNK:0]   w_part  [STAGES];
    logic [WIDTH-1:0] w_s_next;
    logic             w_ovf_next;

    // r_a carries finished low slices of the sum with untouched high slices of lt
    logic [WIDTH-1:0] r_a   [c_NPIPE];
    logic [WIDTH-1:0] r_b   [c_NPIPE];
    logic             r_c   [c_NPIPE];
    logic             r_vld [c_NPIPE];

    logic             r_out_valid;
    logic [WIDTH-1:0] r_s;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    assign w_advance    = !r_out_valid || bus.out_ready;
    assign bus.in_ready = w_advance;

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            localparam logic [WIDTH-1:0] c_SLICE_MASK = WIDTH'({CHUNK{1'b1}}) << (k * CHUNK);

            if (k == 0) begin : g_first
                assign w_a_in[k] = bus.lt;
                assign w_b_in[k] = bus.sub ? ~bus.rt : bus.rt;
                assign w_c_in[k] = bus.cin;
                assign w_v_in[k] = bus.in_valid;
            end else begin : g_next
                assign w_a_in[k] = r_a[k-1];
                assign w_b_in[k] = r_b[k-1];
                assign w_c_in[k] = r_c[k-1];
                assign w_v_in[k] = r_vld[k-1];
            end

            assign w_part[k] = {1'b0, w_a_in[k][k*CHUNK +: CHUNK]}
                             + {1'b0, w_b_in[k][k*CHUNK +: CHUNK]}
                             + {{CHUNK{1'b0}}, w_c_in[k]};

            assign w_a_out[k] = (w_a_in[k] & ~c_SLICE_MASK)
                              | (WIDTH'(w_part[k][CHUNK-1:0]) << (k * CHUNK));
        end
    endgenerate

    // The top slice of lt/rt_eff is still untouched at the last stage's input
    assign w_s_next   = w_a_out[c_LAST];
    assign w_ovf_next = (w_a_in[c_LAST][WIDTH-1] == w_b_in[c_LAST][WIDTH-1])
                     && (w_s_next[WIDTH-1] != w_a_in[c_LAST][WIDTH-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_s         <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
            for (int j = 0; j < c_NPIPE; j++) begin
                r_vld[j] <= 1'b0;
                r_a[j]   <= '0;
                r_b[j]   <= '0;
                r_c[j]   <= 1'b0;
            end
        end else if (w_advance) begin
            r_out_valid <= w_v_in[c_LAST];
            if (w_v_in[c_LAST]) begin
                r_s    <= w_s_next;
                r_cout <= w_part[c_LAST][CHUNK];
                r_ovf  <= w_ovf_next;
                r_zero <= ~|w_s_next;
            end
            for (int j = 0; j < STAGES - 1; j++) begin
                r_vld[j] <= w_v_in[j];
                r_a[j]   <= w_a_out[j];
                r_b[j]   <= w_b_in[j];
                r_c[j]   <= w_part[j][CHUNK];
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.s         = r_s;
    assign bus.cout      = r_cout;
    assign bus.ovf       = r_ovf;
    assign bus.zero      = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_pipelined_adder.sv
// ============================================================================
// Module      : tb_pipelined_adder
// Description : Self-checking bench for pipelined_adder (32/4, 16/16, 64/8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipelined_adder;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   a_lat = 0;
    int   a_pops = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipelined_adder_if #(.WIDTH(32)) ifa ();
    pipelined_adder_if #(.WIDTH(16)) ifb ();
    pipelined_adder_if #(.WIDTH(64)) ifc ();

    pipelined_adder #(.WIDTH(32), .CHUNK(4))  dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    pipelined_adder #(.WIDTH(16), .CHUNK(16)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));
    pipelined_adder #(.WIDTH(64), .CHUNK(8))  dut_c (.clk(clk), .rst(rst), .bus(ifc.slave));

    typedef struct {
        logic [63:0] s;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          t;
        int          lat;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    // Plain wide arithmetic reference: result of one operation of width w
    function automatic exp_t model(input int w, input logic [63:0] l, input logic [63:0] r,
                                   input logic c, input logic sb);
        exp_t        res;
        logic [64:0] mask;
        logic [64:0] rte;
        logic [64:0] full;
        mask     = (65'd1 << w) - 65'd1;
        rte      = {1'b0, (sb ? ~r : r)} & mask;
        full     = ({1'b0, l} & mask) + rte + 65'(c);
        res.s    = full[63:0] & mask[63:0];
        res.cout = full[w];
        res.zero = (res.s == 64'd0);
        res.ovf  = (l[w-1] == rte[w-1]) && (res.s[w-1] != l[w-1]);
        res.t    = cyc;
        res.lat  = 0;
        return res;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic check_out(input string nm, input exp_t e, input logic [63:0] s,
                             input logic cout, input logic ovf, input logic zero);
        chk({nm, "_s"},    s,           e.s);
        chk({nm, "_cout"}, 64'(cout),   64'(e.cout));
        chk({nm, "_ovf"},  64'(ovf),    64'(e.ovf));
        chk({nm, "_zero"}, 64'(zero),   64'(e.zero));
        if (e.lat != 0) chk({nm, "_latency"}, 64'(cyc - e.t), 64'(e.lat));
    endtask

    // Single compare process: scoreboards for all three instances
    logic        hold_a;
    logic [35:0] prev_a;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            qa.delete(); qb.delete(); qc.delete();
            hold_a = 1'b0;
        end else begin
            chk("in_ready_a", 64'(ifa.in_ready), 64'(!ifa.out_valid || ifa.out_ready));
            if (hold_a)
                chk("hold_a", 64'({ifa.out_valid, ifa.cout, ifa.ovf, ifa.zero, ifa.s}), 64'(prev_a));
            if (ifa.in_valid && ifa.in_ready) begin
                e = model(32, 64'(ifa.lt), 64'(ifa.rt), ifa.cin, ifa.sub);
                e.lat = a_lat;
                qa.push_back(e);
            end
            if (ifa.out_valid && ifa.out_ready) begin
                a_pops++;
                chk("pending_a", 64'(qa.size() != 0), 64'd1);
                if (qa.size() != 0) check_out("a", qa.pop_front(), 64'(ifa.s), ifa.cout, ifa.ovf, ifa.zero);
            end
            hold_a = ifa.out_valid && !ifa.out_ready;
            prev_a = {ifa.out_valid, ifa.cout, ifa.ovf, ifa.zero, ifa.s};

            if (ifb.in_valid && ifb.in_ready) begin
                e = model(16, 64'(ifb.lt), 64'(ifb.rt), ifb.cin, ifb.sub);
                e.lat = 1;
                qb.push_back(e);
            end
            if (ifb.out_valid && ifb.out_ready) begin
                chk("pending_b", 64'(qb.size() != 0), 64'd1);
                if (qb.size() != 0) check_out("b", qb.pop_front(), 64'(ifb.s), ifb.cout, ifb.ovf, ifb.zero);
            end

            if (ifc.in_valid && ifc.in_ready) begin
                e = model(64, ifc.lt, ifc.rt, ifc.cin, ifc.sub);
                e.lat = 8;
                qc.push_back(e);
            end
            if (ifc.out_valid && ifc.out_ready) begin
                chk("pending_c", 64'(qc.size() != 0), 64'd1);
                if (qc.size() != 0) check_out("c", qc.pop_front(), ifc.s, ifc.cout, ifc.ovf, ifc.zero);
            end
        end
    end

    task automatic send_a(input logic [31:0] l, input logic [31:0] r, input logic c, input logic sb);
        int n = 0;
        ifa.in_valid = 1'b1; ifa.lt = l; ifa.rt = r; ifa.cin = c; ifa.sub = sb;
        @(negedge clk);
        while (!ifa.in_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) chk("send_a_timeout", 64'(n), 64'd0);
        @(posedge clk); #1;
        ifa.in_valid = 1'b0;
    endtask

    task automatic wait_valid_a(output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!ifa.out_valid && k < 60);
    endtask

    task automatic reset_checks_a(input string nm);
        chk({nm, "_out_valid"}, 64'(ifa.out_valid), 64'd0);
        chk({nm, "_s"},         64'(ifa.s),         64'd0);
        chk({nm, "_cout"},      64'(ifa.cout),      64'd0);
        chk({nm, "_ovf"},       64'(ifa.ovf),       64'd0);
        chk({nm, "_zero"},      64'(ifa.zero),      64'd0);
        chk({nm, "_in_ready"},  64'(ifa.in_ready),  64'd1);
    endtask

    initial begin
        int k;
        int n0;
        rst = 1'b1;
        ifa.in_valid = 0; ifa.lt = 0; ifa.rt = 0; ifa.cin = 0; ifa.sub = 0; ifa.out_ready = 1;
        ifb.in_valid = 0; ifb.lt = 0; ifb.rt = 0; ifb.cin = 0; ifb.sub = 0; ifb.out_ready = 1;
        ifc.in_valid = 0; ifc.lt = 0; ifc.rt = 0; ifc.cin = 0; ifc.sub = 0; ifc.out_ready = 1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        reset_checks_a("reset_a");
        chk("reset_b_out_valid", 64'(ifb.out_valid), 64'd0);
        chk("reset_c_out_valid", 64'(ifc.out_valid), 64'd0);
        chk("reset_c_s",         ifc.s,              64'd0);
        @(posedge clk); #1;

        // Full carry ripple through every stage
        a_lat = 8;
        send_a(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0);
        wait_valid_a(k);
        chk("t1_latency", 64'(k), 64'd8);
        chk("t1_s",    64'(ifa.s),    64'd0);
        chk("t1_cout", 64'(ifa.cout), 64'd1);
        chk("t1_zero", 64'(ifa.zero), 64'd1);
        chk("t1_ovf",  64'(ifa.ovf),  64'd0);
        @(posedge clk); #1;

        // Subtraction: borrow, then signed overflow
        send_a(32'd5, 32'd7, 1'b1, 1'b1);
        send_a(32'h8000_0000, 32'd1, 1'b1, 1'b1);
        wait_valid_a(k);
        chk("t2a_s",    64'(ifa.s),    64'hFFFF_FFFE);
        chk("t2a_cout", 64'(ifa.cout), 64'd0);
        chk("t2a_ovf",  64'(ifa.ovf),  64'd0);
        chk("t2a_zero", 64'(ifa.zero), 64'd0);
        @(negedge clk);
        chk("t2b_valid", 64'(ifa.out_valid), 64'd1);
        chk("t2b_s",     64'(ifa.s),    64'h7FFF_FFFF);
        chk("t2b_cout",  64'(ifa.cout), 64'd1);
        chk("t2b_ovf",   64'(ifa.ovf),  64'd1);
        @(posedge clk); #1;

        // Back-to-back stream, exact latency enforced per op
        n0 = a_pops;
        for (int i = 0; i < 20; i++)
            send_a($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        repeat (10) @(posedge clk);
        #1 chk("t3_count", 64'(a_pops - n0), 64'd20);

        // Backpressure: fill, stall 5 cycles, release
        a_lat = 0;
        ifa.out_ready = 1'b0;
        n0 = a_pops;
        fork
            begin
                for (int i = 0; i < 10; i++)
                    send_a($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            begin
                repeat (12) @(negedge clk);
                repeat (5) begin
                    @(negedge clk);
                    chk("t4_in_ready",  64'(ifa.in_ready),  64'd0);
                    chk("t4_out_valid", 64'(ifa.out_valid), 64'd1);
                end
                @(posedge clk); #1;
                ifa.out_ready = 1'b1;
            end
        join
        repeat (20) @(posedge clk);
        #1 chk("t4_count", 64'(a_pops - n0), 64'd10);
        chk("t4_drained", 64'(qa.size()), 64'd0);

        // Reset with four ops in flight
        for (int i = 0; i < 4; i++) send_a($urandom, $urandom, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        reset_checks_a("t5");
        n0 = a_pops;
        repeat (15) @(posedge clk);
        #1 chk("t5_no_stale", 64'(a_pops - n0), 64'd0);

        // Single-stage 16-bit and 8-stage 64-bit instances, random with bubbles
        for (int i = 0; i < 40; i++) begin
            ifb.in_valid = (i < 2) || ($urandom_range(0, 3) != 0);
            ifc.in_valid = (i < 2) || ($urandom_range(0, 3) != 0);
            ifb.lt = 16'($urandom); ifb.rt = 16'($urandom);
            ifb.cin = 1'($urandom_range(0, 1)); ifb.sub = 1'($urandom_range(0, 1));
            ifc.lt = {$urandom, $urandom}; ifc.rt = {$urandom, $urandom};
            ifc.cin = 1'($urandom_range(0, 1)); ifc.sub = 1'($urandom_range(0, 1));
            if (i == 0) begin
                ifb.lt = 16'hFFFF; ifb.rt = 16'h0001; ifb.cin = 0; ifb.sub = 0;
                ifc.lt = 64'h7FFF_FFFF_FFFF_FFFF; ifc.rt = 64'd1; ifc.cin = 0; ifc.sub = 0;
            end else if (i == 1) begin
                ifb.lt = 16'h8000; ifb.rt = 16'h0001; ifb.cin = 1; ifb.sub = 1;
                ifc.lt = 64'd0; ifc.rt = 64'd0; ifc.cin = 1; ifc.sub = 1;
            end
            @(posedge clk); #1;
        end
        ifb.in_valid = 1'b0;
        ifc.in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("t6_b_drained", 64'(qb.size()), 64'd0);
        chk("t6_c_drained", 64'(qc.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
